// File: rtl/camera_pkg.sv
// Shared camera-controller types and defaults.
// Used by the exposure timer and the camera control FSM.
package camera_pkg;

  localparam int CAM_CNT_W       = 5;
  localparam int CAM_EXP_MIN     = 2;
  localparam int CAM_EXP_MAX     = 30;
  localparam int CAM_EXP_DEFAULT = 15;
  localparam int CAM_PRESCALE    = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Prescaler counter width, never below one bit.
  function automatic int pre_w(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to one tick every PRESCALE enabled cycles.
// clr restarts the phase so a fresh run always gets a full first tick.
module tick_prescaler
  import camera_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = pre_w(PRESCALE);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (Reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/exposure_timer.sv
// Programmable exposure timer: holds the exposure setting and
// counts it down at the prescaled rate, pulsing Ovf at the end.
module exposure_timer
  import camera_pkg::*;
#(
  parameter int CNT_W       = CAM_CNT_W,
  parameter int EXP_MIN     = CAM_EXP_MIN,
  parameter int EXP_MAX     = CAM_EXP_MAX,
  parameter int EXP_DEFAULT = CAM_EXP_DEFAULT,
  parameter int PRESCALE    = CAM_PRESCALE
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Init,
  input  logic             Start,
  input  logic             Exp_inc,
  input  logic             Exp_dec,
  output logic [CNT_W-1:0] Exp_time,
  output logic [CNT_W-1:0] Count,
  output logic             Busy,
  output logic             Ovf
);

  localparam logic [CNT_W-1:0] MIN = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(EXP_MAX);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(EXP_DEFAULT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t state;
  logic   run;
  logic   clr;
  logic   tick;

  assign run = (state == ST_RUN);
  assign clr = !run && Start && !Init;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_pre (
    .clk  (clk),
    .Reset(Reset),
    .clr  (clr),
    .en   (run),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      Exp_time <= DEF;
      Count    <= '0;
      Busy     <= 1'b0;
      Ovf      <= 1'b0;
    end else begin
      Ovf <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Init) begin
            Exp_time <= DEF;
          end else if (Start) begin
            Count <= Exp_time;
            Busy  <= 1'b1;
            state <= ST_RUN;
          end else if (Exp_inc && !Exp_dec) begin
            if (Exp_time < MAX)
              Exp_time <= Exp_time + ONE;
          end else if (Exp_dec && !Exp_inc) begin
            if (Exp_time > MIN)
              Exp_time <= Exp_time - ONE;
          end
        end
        ST_RUN: begin
          // An abort on the final tick suppresses the pulse.
          if (Init) begin
            Exp_time <= DEF;
            Count    <= '0;
            Busy     <= 1'b0;
            state    <= ST_IDLE;
          end else if (tick) begin
            if (Count <= ONE) begin
              Count <= '0;
              Busy  <= 1'b0;
              Ovf   <= 1'b1;
              state <= ST_IDLE;
            end else begin
              Count <= Count - ONE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
          Count <= '0;
        end
      endcase
    end
  end

endmodule
